// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared types for the ID-stage branch hazard controller: shadow-stage entry,
// FSM state encoding and the producer/consumer dependency helper.
package branch_hazard_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam logic [2:0] RUN_MAX = 3'd7;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              m2r;
  } stage_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_e;

  // A stage feeds register r only if it is live, writes, and is not $0.
  function automatic logic dep(stage_t s, logic [REG_AW-1:0] r);
    return s.vld & s.rw & (s.rd != '0) & (s.rd == r);
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_hz_stage_reg.sv
// One shadow pipeline stage: async clear, hold has priority over the
// synchronous clear used to inject a bubble.
module hz_stage_reg
  import branch_hazard_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   clear,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= clear ? '0 : d;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch hazard control for ID-stage beq/bne resolution: shadows EX/MEM/WB
// writes, stalls ID and bubbles EX until operands are forwardable from MEM/WB.
// Optional statistics counters are built when BRANCH_STALL_STATS_EN is defined.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
`ifdef BRANCH_STALL_STATS_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_stall,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memtoreg,
  input  logic              id_beq,
  input  logic              id_bne,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic [REG_AW-1:0] writereg_mem,
  output logic              regwrite_mem,
  output logic [REG_AW-1:0] writereg_wb,
  output logic              regwrite_wb,
  output logic              memtoreg_wb,
`ifdef BRANCH_STALL_STATS_EN
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_stalls,
`endif
  output logic [2:0]        stall_run,
  output hz_state_e         dbg_state
);

  stage_t    idEntry, exStage, memStage, wbStage;
  logic      isBranch, hazard;
  hz_state_e state, nextState;
  logic [2:0] runCnt, nextCnt;

  assign idEntry  = '{vld: id_valid, rd: id_rd, rw: id_regwrite, m2r: id_memtoreg};
  assign isBranch = id_valid & (id_beq | id_bne);

  // ALU results become forwardable in MEM; load data only in WB.
  assign hazard = isBranch &
                  (dep(exStage, id_rs) | dep(exStage, id_rt) |
                   (memStage.m2r & (dep(memStage, id_rs) | dep(memStage, id_rt))));

  assign stall_id  = hazard | ext_stall;
  assign bubble_ex = hazard & ~ext_stall;

  hz_stage_reg u_ex (
    .clk(clk), .rst(rst), .hold(ext_stall), .clear(hazard), .d(idEntry), .q(exStage)
  );
  hz_stage_reg u_mem (
    .clk(clk), .rst(rst), .hold(ext_stall), .clear(1'b0), .d(exStage), .q(memStage)
  );
  hz_stage_reg u_wb (
    .clk(clk), .rst(rst), .hold(ext_stall), .clear(1'b0), .d(memStage), .q(wbStage)
  );

  assign writereg_mem = memStage.vld ? memStage.rd : '0;
  assign regwrite_mem = memStage.vld & memStage.rw;
  assign writereg_wb  = wbStage.vld ? wbStage.rd : '0;
  assign regwrite_wb  = wbStage.vld & wbStage.rw;
  assign memtoreg_wb  = wbStage.vld & wbStage.m2r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      runCnt <= '0;
    end else begin
      state  <= nextState;
      runCnt <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = runCnt;
    if (!ext_stall) begin
      if (hazard) begin
        nextState = HOLD;
        nextCnt   = (runCnt == RUN_MAX) ? runCnt : runCnt + 3'd1;
      end else begin
        nextState = RUN;
        nextCnt   = '0;
      end
    end
  end

  assign stall_run = runCnt;
  assign dbg_state = state;

`ifdef BRANCH_STALL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches <= '0;
      stat_stalls   <= '0;
    end else begin
      if (isBranch & ~stall_id) stat_branches <= stat_branches + 1'b1;
      if (bubble_ex)            stat_stalls   <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule
